// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and helpers for the memory request arbiter.
//   ADDR_W / DATA_W : default address/data widths. mem_req_t is sized by them,
//                     so the arbiter's LEN_ADDR/LEN_DATA must keep these values.
//   MAX_REQ         : largest supported requester count (decode width).
//   mem_req_t       : one forwarded request (addr, data, wrt_enbl).
//   tag_w()         : tag width for a given requester count.
//   onehot_decode() : requester index -> one-hot vector.
package mem_arb_pkg;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 512;
  localparam int MAX_REQ   = 8;
  localparam int TAG_MAX_W = 3;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              wrt_enbl;
  } mem_req_t;

  function automatic int tag_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  function automatic logic [MAX_REQ-1:0] onehot_decode(input logic [TAG_MAX_W-1:0] idx);
    logic [MAX_REQ-1:0] hot;
    hot      = '0;
    hot[idx] = 1'b1;
    return hot;
  endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Bus interfaces of the memory request arbiter.
//   mem_req_if : requester side. master = PE load/store units, slave = arbiter.
//     req_available/req_wrt_enbl/req_addr/req_data (packed per requester),
//     req_ready (one-hot grant), rsp_data/rsp_valid (read return).
//   mem_dma_if : DMA side. master = arbiter, slave = DMA issue block.
//     dma_addr/dma_data/dma_wrt_enbl/dma_available (issue),
//     dma_ready_to_receive (issue flow control),
//     dma_in_data/dma_data_ready/dma_receive_enbl (FWFT return FIFO).
interface mem_req_if #(
  parameter int NUM_REQ  = 4,
  parameter int LEN_ADDR = 32,
  parameter int LEN_DATA = 512
);
  logic [NUM_REQ-1:0]          req_available;
  logic [NUM_REQ-1:0]          req_wrt_enbl;
  logic [NUM_REQ*LEN_ADDR-1:0] req_addr;
  logic [NUM_REQ*LEN_DATA-1:0] req_data;
  logic [NUM_REQ-1:0]          req_ready;
  logic [LEN_DATA-1:0]         rsp_data;
  logic [NUM_REQ-1:0]          rsp_valid;

  modport master (
    output req_available, req_wrt_enbl, req_addr, req_data,
    input  req_ready, rsp_data, rsp_valid
  );

  modport slave (
    input  req_available, req_wrt_enbl, req_addr, req_data,
    output req_ready, rsp_data, rsp_valid
  );
endinterface

interface mem_dma_if #(
  parameter int LEN_ADDR = 32,
  parameter int LEN_DATA = 512
);
  logic [LEN_ADDR-1:0] dma_addr;
  logic [LEN_DATA-1:0] dma_data;
  logic                dma_wrt_enbl;
  logic                dma_available;
  logic                dma_ready_to_receive;
  logic [LEN_DATA-1:0] dma_in_data;
  logic                dma_data_ready;
  logic                dma_receive_enbl;

  modport master (
    output dma_addr, dma_data, dma_wrt_enbl, dma_available, dma_receive_enbl,
    input  dma_ready_to_receive, dma_in_data, dma_data_ready
  );

  modport slave (
    input  dma_addr, dma_data, dma_wrt_enbl, dma_available, dma_receive_enbl,
    output dma_ready_to_receive, dma_in_data, dma_data_ready
  );
endinterface

// File: rtl/mem_arb_tag_fifo.sv
// mem_arb_tag_fifo
// In-order tag queue: records which requester issued each outstanding read.
//   clk, rst (async, active-low)
//   push/din  : enqueue a tag (ignored when full)
//   pop/dout  : dequeue; dout is the head (valid while !empty)
//   empty/full: occupancy flags
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module mem_arb_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign dout    = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // NOTE: storage has no reset; entries are only read after being written,
  // and leaving them unreset keeps the array in plain RAM/flops without a reset tree.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
// Shares the DDR DMA issue port between NUM_REQ requesters and steers in-order
// read data back to its issuer.
//   clk, rst (async, active-low; req_ready/dma_receive_enbl forced low in reset)
//   req_bus  : mem_req_if.slave  (requests in, one-hot grant, read responses)
//   dma_bus  : mem_dma_if.master (registered issue stage, FWFT return pop)
//   outstanding_cnt : reads issued and not yet returned
//   err_orphan      : sticky, return data arrived with an empty tag queue
// Build option: define MEM_ARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins); default is round-robin starting after the last accepted requester.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int NUM_REQ         = 4,
  parameter  int LEN_ADDR        = ADDR_W,
  parameter  int LEN_DATA        = DATA_W,
  parameter  int MAX_OUTSTANDING = 14,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             rst,
  mem_req_if.slave         req_bus,
  mem_dma_if.master        dma_bus,
  output logic [CNT_W-1:0] outstanding_cnt,
  output logic             err_orphan
);

  localparam int TW = tag_w(NUM_REQ);

  logic [NUM_REQ-1:0]  eligible, grant;
  logic [TW-1:0]       grant_idx, tag_head;
  logic                credit_ok, accept, rd_push, pop, tag_pop;
  logic                tag_empty, tag_full;
  logic [MAX_REQ-1:0]  tag_hot;
  mem_req_t            req_sel, out_q;
  logic                avail_q;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic [LEN_DATA-1:0] rsp_data_q;

  // Registered count makes the credit check conservative by at most one read.
  assign credit_ok = outstanding_cnt < CNT_W'(MAX_OUTSTANDING);

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++)
      eligible[i] = rst && req_bus.req_available[i] && dma_bus.dma_ready_to_receive
                    && (req_bus.req_wrt_enbl[i] || credit_ok);
  end

`ifdef MEM_ARB_FIXED_PRIO_EN
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    // Descending scan: the lowest eligible index is written last and wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = TW'(i);
      end
    end
  end
`else
  logic [TW-1:0] last_grant;

  always_comb begin
    logic [TW-1:0] idx;
    logic          found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = TW'((int'(last_grant) + k) % NUM_REQ);
      if (!found && eligible[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  // Reset to the top index so requester 0 is searched first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        last_grant <= TW'(NUM_REQ - 1);
    else if (accept) last_grant <= grant_idx;
  end
`endif

  always_comb begin
    req_sel.addr     = req_bus.req_addr[int'(grant_idx)*LEN_ADDR +: LEN_ADDR];
    req_sel.data     = req_bus.req_data[int'(grant_idx)*LEN_DATA +: LEN_DATA];
    req_sel.wrt_enbl = req_bus.req_wrt_enbl[grant_idx];
  end

  assign accept  = |grant;
  assign rd_push = accept && !req_sel.wrt_enbl;
  assign pop     = rst && dma_bus.dma_data_ready;
  assign tag_pop = pop && !tag_empty;
  assign tag_hot = onehot_decode(TAG_MAX_W'(tag_head));

  assign req_bus.req_ready        = grant;
  assign req_bus.rsp_valid        = rsp_valid_q;
  assign req_bus.rsp_data         = rsp_data_q;
  assign dma_bus.dma_receive_enbl = pop;
  assign dma_bus.dma_available    = avail_q;
  assign dma_bus.dma_addr         = out_q.addr;
  assign dma_bus.dma_data         = out_q.data;
  assign dma_bus.dma_wrt_enbl     = out_q.wrt_enbl;

  mem_arb_tag_fifo #(
    .WIDTH (TW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_push && !tag_full),
    .din   (grant_idx),
    .pop   (tag_pop),
    .dout  (tag_head),
    .empty (tag_empty),
    .full  (tag_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      avail_q         <= 1'b0;
      out_q           <= '0;
      outstanding_cnt <= '0;
      rsp_valid_q     <= '0;
      rsp_data_q      <= '0;
      err_orphan      <= 1'b0;
    end else begin
      avail_q <= accept;
      if (accept) out_q <= req_sel;

      // Simultaneous read accept and tagged pop cancel out.
      if (rd_push && !tag_pop)      outstanding_cnt <= outstanding_cnt + 1'b1;
      else if (tag_pop && !rd_push) outstanding_cnt <= outstanding_cnt - 1'b1;

      // Orphan data (pop with no tag) is dropped without a qualifier.
      rsp_valid_q <= tag_pop ? tag_hot[NUM_REQ-1:0] : '0;
      if (tag_pop) rsp_data_q <= dma_bus.dma_in_data;
      if (pop && tag_empty) err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
module tb_mem_req_arbiter;

  localparam int N  = 4;
  localparam int LA = 32;
  localparam int LD = 512;
  localparam int MO = 14;
  localparam int CW = $clog2(MO + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CW-1:0] outstanding_cnt;
  logic          err_orphan;

  int n_vec = 0;
  int n_err = 0;

  mem_req_if #(.NUM_REQ(N), .LEN_ADDR(LA), .LEN_DATA(LD)) req_bus ();
  mem_dma_if #(.LEN_ADDR(LA), .LEN_DATA(LD)) dma_bus ();

  mem_req_arbiter #(
    .NUM_REQ(N), .LEN_ADDR(LA), .LEN_DATA(LD), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_bus         (req_bus.slave),
    .dma_bus         (dma_bus.master),
    .outstanding_cnt (outstanding_cnt),
    .err_orphan      (err_orphan)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (spec-level) ----------------
  int              tag_q[$];
  int              last_grant;
  logic            exp_avail;
  logic [LA-1:0]   exp_addr;
  logic [LD-1:0]   exp_data;
  logic            exp_wr;
  logic [N-1:0]    exp_rsp_valid;
  logic [LD-1:0]   exp_rsp_data;
  logic            exp_orphan;
  logic [N-1:0]    obs_ready;

  function automatic void model_reset();
    tag_q.delete();
    last_grant    = N - 1;
    exp_avail     = 1'b0;
    exp_addr      = '0;
    exp_data      = '0;
    exp_wr        = 1'b0;
    exp_rsp_valid = '0;
    exp_rsp_data  = '0;
    exp_orphan    = 1'b0;
  endfunction

  function automatic int model_grant();
    bit elig[N];
    if (!rst) return -1;
    for (int i = 0; i < N; i++)
      elig[i] = req_bus.req_available[i] && dma_bus.dma_ready_to_receive &&
                (req_bus.req_wrt_enbl[i] || tag_q.size() < MO);
`ifdef MEM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (elig[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (elig[(last_grant + k) % N]) return (last_grant + k) % N;
`endif
    return -1;
  endfunction

  function automatic logic [LD-1:0] rand_data();
    logic [LD-1:0] d;
    for (int i = 0; i < LD / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic rand_payload();
    for (int i = 0; i < N; i++) begin
      req_bus.req_addr[i*LA +: LA] = $urandom;
      req_bus.req_data[i*LD +: LD] = rand_data();
    end
    dma_bus.dma_in_data = rand_data();
  endtask

  task automatic idle_inputs();
    req_bus.req_available        = '0;
    req_bus.req_wrt_enbl         = '0;
    dma_bus.dma_ready_to_receive = 1'b1;
    dma_bus.dma_data_ready       = 1'b0;
    rand_payload();
  endtask

  // One clock: inputs are already set (at posedge+1); checks the
  // combinational outputs, advances the model, then checks registered outputs.
  task automatic cycle();
    int           g;
    logic [N-1:0] exp_ready;
    #1;
    g         = model_grant();
    exp_ready = (g >= 0) ? (N'(1) << g) : '0;
    obs_ready = req_bus.req_ready;
    n_vec++;
    if (req_bus.req_ready !== exp_ready) begin
      n_err++;
      $display("FAIL req_ready: got %b expected %b", req_bus.req_ready, exp_ready);
    end
    n_vec++;
    if (dma_bus.dma_receive_enbl !== dma_bus.dma_data_ready) begin
      n_err++;
      $display("FAIL receive_enbl: got %b expected %b", dma_bus.dma_receive_enbl, dma_bus.dma_data_ready);
    end
    exp_rsp_valid = '0;
    if (dma_bus.dma_data_ready) begin
      if (tag_q.size() > 0) begin
        exp_rsp_valid = N'(1) << tag_q.pop_front();
        exp_rsp_data  = dma_bus.dma_in_data;
      end else begin
        exp_orphan = 1'b1;
      end
    end
    exp_avail = (g >= 0);
    if (g >= 0) begin
      exp_addr   = req_bus.req_addr[g*LA +: LA];
      exp_data   = req_bus.req_data[g*LD +: LD];
      exp_wr     = req_bus.req_wrt_enbl[g];
      last_grant = g;
      if (!exp_wr) tag_q.push_back(g);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (dma_bus.dma_available !== exp_avail) begin
      n_err++;
      $display("FAIL dma_available: got %b expected %b", dma_bus.dma_available, exp_avail);
    end
    if (exp_avail) begin
      n_vec++;
      if (dma_bus.dma_addr !== exp_addr || dma_bus.dma_wrt_enbl !== exp_wr ||
          dma_bus.dma_data !== exp_data) begin
        n_err++;
        $display("FAIL dma_issue: got addr %h wr %b expected addr %h wr %b (data match %0d)",
                 dma_bus.dma_addr, dma_bus.dma_wrt_enbl, exp_addr, exp_wr,
                 dma_bus.dma_data === exp_data);
      end
    end
    n_vec++;
    if (req_bus.rsp_valid !== exp_rsp_valid) begin
      n_err++;
      $display("FAIL rsp_valid: got %b expected %b", req_bus.rsp_valid, exp_rsp_valid);
    end
    if (exp_rsp_valid != '0) begin
      n_vec++;
      if (req_bus.rsp_data !== exp_rsp_data) begin
        n_err++;
        $display("FAIL rsp_data: got %h expected %h", req_bus.rsp_data[63:0], exp_rsp_data[63:0]);
      end
    end
    n_vec++;
    if (outstanding_cnt !== CW'(tag_q.size())) begin
      n_err++;
      $display("FAIL outstanding_cnt: got %0d expected %0d", outstanding_cnt, tag_q.size());
    end
    n_vec++;
    if (err_orphan !== exp_orphan) begin
      n_err++;
      $display("FAIL err_orphan: got %b expected %b", err_orphan, exp_orphan);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic check_all_zero(input string tag);
    n_vec++;
    if (req_bus.req_ready !== '0 || dma_bus.dma_receive_enbl !== 1'b0 ||
        dma_bus.dma_available !== 1'b0 || dma_bus.dma_addr !== '0 ||
        dma_bus.dma_data !== '0 || dma_bus.dma_wrt_enbl !== 1'b0 ||
        req_bus.rsp_valid !== '0 || req_bus.rsp_data !== '0 ||
        outstanding_cnt !== '0 || err_orphan !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got ready %b rcv %b avail %b addr %h wr %b rsp_valid %b cnt %0d orphan %b expected all 0",
               tag, req_bus.req_ready, dma_bus.dma_receive_enbl, dma_bus.dma_available,
               dma_bus.dma_addr, dma_bus.dma_wrt_enbl, req_bus.rsp_valid, outstanding_cnt, err_orphan);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    req_bus.req_available  = '1;
    dma_bus.dma_data_ready = 1'b1;
    #2;
    check_all_zero("reset_state");
    @(posedge clk);
    #1;
    check_all_zero("reset_hold");
    do_reset();
  endtask

  task automatic test_round_robin();
    int exp_g;
    do_reset();
    req_bus.req_available = 4'b0101;
    req_bus.req_wrt_enbl  = '0;
    for (int c = 0; c < 8; c++) begin
      rand_payload();
      cycle();
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_g = 0;
`else
      exp_g = (c % 2 == 0) ? 0 : 2;
`endif
      n_vec++;
      if (obs_ready !== (N'(1) << exp_g) || dma_bus.dma_available !== 1'b1) begin
        n_err++;
        $display("FAIL rr_alternate[%0d]: got grant %b avail %b expected grant %0d avail 1",
                 c, obs_ready, dma_bus.dma_available, exp_g);
      end
    end
  endtask

  task automatic test_credit_limit();
    do_reset();
    req_bus.req_available = 4'b0010;
    for (int c = 0; c < MO; c++) begin
      rand_payload();
      cycle();
    end
    rand_payload();
    cycle();
    n_vec++;
    if (obs_ready !== 4'b0000 || outstanding_cnt !== CW'(MO)) begin
      n_err++;
      $display("FAIL credit_block: got grant %b cnt %0d expected grant 0000 cnt %0d",
               obs_ready, outstanding_cnt, MO);
    end
    req_bus.req_available = 4'b1010;
    req_bus.req_wrt_enbl  = 4'b1000;
    rand_payload();
    cycle();
    n_vec++;
    if (obs_ready !== 4'b1000 || dma_bus.dma_wrt_enbl !== 1'b1 || outstanding_cnt !== CW'(MO)) begin
      n_err++;
      $display("FAIL credit_write_pass: got grant %b wr %b cnt %0d expected 1000 1 %0d",
               obs_ready, dma_bus.dma_wrt_enbl, outstanding_cnt, MO);
    end
  endtask

  task automatic test_return_order();
    logic [N-1:0]  exp_hot[3];
    logic [LD-1:0] d;
    exp_hot[0] = 4'b1000;
    exp_hot[1] = 4'b0010;
    exp_hot[2] = 4'b1000;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      req_bus.req_available = exp_hot[c];
      rand_payload();
      cycle();
    end
    req_bus.req_available  = '0;
    dma_bus.dma_data_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      rand_payload();
      d = dma_bus.dma_in_data;
      cycle();
      n_vec++;
      if (req_bus.rsp_valid !== exp_hot[c] || req_bus.rsp_data !== d) begin
        n_err++;
        $display("FAIL return_order[%0d]: got valid %b data %h expected valid %b data %h",
                 c, req_bus.rsp_valid, req_bus.rsp_data[31:0], exp_hot[c], d[31:0]);
      end
    end
    dma_bus.dma_data_ready = 1'b0;
  endtask

  task automatic test_push_pop_same_cycle();
    int order[6];
    do_reset();
    for (int c = 0; c < 6; c++) order[c] = $urandom_range(N - 1);
    for (int c = 0; c < 5; c++) begin
      req_bus.req_available = N'(1) << order[c];
      rand_payload();
      cycle();
    end
    req_bus.req_available  = N'(1) << order[5];
    dma_bus.dma_data_ready = 1'b1;
    rand_payload();
    cycle();
    n_vec++;
    if (outstanding_cnt !== CW'(5) || req_bus.rsp_valid !== (N'(1) << order[0])) begin
      n_err++;
      $display("FAIL push_pop_count: got cnt %0d valid %b expected cnt 5 valid %b",
               outstanding_cnt, req_bus.rsp_valid, N'(1) << order[0]);
    end
    req_bus.req_available = '0;
    for (int c = 1; c < 6; c++) begin
      rand_payload();
      cycle();
      n_vec++;
      if (req_bus.rsp_valid !== (N'(1) << order[c])) begin
        n_err++;
        $display("FAIL push_pop_order[%0d]: got %b expected %b", c, req_bus.rsp_valid, N'(1) << order[c]);
      end
    end
    dma_bus.dma_data_ready = 1'b0;
  endtask

  task automatic test_orphan();
    do_reset();
    dma_bus.dma_data_ready = 1'b1;
    cycle();
    n_vec++;
    if (err_orphan !== 1'b1 || req_bus.rsp_valid !== '0 || outstanding_cnt !== '0) begin
      n_err++;
      $display("FAIL orphan: got orphan %b valid %b cnt %0d expected 1 0000 0",
               err_orphan, req_bus.rsp_valid, outstanding_cnt);
    end
    dma_bus.dma_data_ready = 1'b0;
    repeat (2) cycle();
    n_vec++;
    if (err_orphan !== 1'b1) begin
      n_err++;
      $display("FAIL orphan_sticky: got %b expected 1", err_orphan);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      req_bus.req_available = N'(1) << $urandom_range(N - 1);
      rand_payload();
      cycle();
    end
    req_bus.req_available  = '1;
    dma_bus.dma_data_ready = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("reset_midflight");
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    dma_bus.dma_data_ready = 1'b0;
    req_bus.req_available  = '1;
    req_bus.req_wrt_enbl   = '0;
    cycle();
    n_vec++;
    if (obs_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL first_grant_after_reset: got %b expected 0001", obs_ready);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_bus.req_available        = N'($urandom);
      req_bus.req_wrt_enbl         = N'($urandom);
      dma_bus.dma_ready_to_receive = ($urandom_range(3) != 0);
      dma_bus.dma_data_ready       = ($urandom_range(9) < 3);
      rand_payload();
      cycle();
    end
    idle_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_round_robin();
    test_credit_limit();
    test_return_order();
    test_push_pop_same_cycle();
    test_orphan();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
